forward_scoreboard: RTL and testbench
=====================================

FORWARD_SCOREBOARD -- requirements
Module: forward_scoreboard

Interface
REQ-001 Parameter NUM_SRC, default 2: number of consumer source-register ports.
REQ-002 Parameter DEPTH, default 2, legal range 2..8: number of tracked in-flight producer stages (stage 1 = youngest).
REQ-003 Parameter LAT_W, default 2: width of the producer latency field.
REQ-004 Localparam SEL_W = clog2(DEPTH+1): width of one forward select.
REQ-005 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst_i  in  1  reset, asynchronous, active-low.
REQ-007 issue_valid_i  in  1  a valid instruction is present in EX.
REQ-008 issue_rd_i  in  5  destination register of the EX instruction.
REQ-009 issue_regwrite_i  in  1  the EX instruction writes issue_rd_i.
REQ-010 issue_is_load_i  in  1  the EX instruction is a load.
REQ-011 issue_lat_i  in  LAT_W  extra result latency of a non-load op; port exists only with FWD_MULTICYCLE_EN.
REQ-012 src_rs_i  in  NUM_SRC*5  source registers of the EX instruction; port n occupies bits [5n+4:5n].
REQ-013 src_use_i  in  NUM_SRC  per-port flag: the instruction actually reads that source.
REQ-014 flush_i  in  1  kill the EX instruction this cycle.
REQ-015 fwd_sel_o  out  NUM_SRC*SEL_W  per-port select: 0 = register file, k = stage k.
REQ-016 stall_o  out  1  hold EX and insert a bubble into stage 1.
REQ-017 stall_cnt_o  out  16  saturating count of stall cycles.

Function
REQ-018 Each stage entry SHALL hold valid, rd, regwrite and rem, where rem is the number of cycles until the result is ready.
REQ-019 An entry SHALL match port n when valid && regwrite && rd != 0 && rd == src n && src_use_i[n].
REQ-020 fwd_sel for port n SHALL equal the smallest matching stage index k, or 0 when no stage matches or src n == 0 (combinational, same cycle).
REQ-021 stall_o SHALL be 1 when issue_valid_i && !flush_i && some port's selected stage has rem != 0; otherwise 0.
REQ-022 Every edge: stage[k] <= stage[k-1] for k = 2..DEPTH, with rem decremented and saturating at 0; stage[DEPTH] is discarded.
REQ-023 stage[1] SHALL load the EX instruction when issue_valid_i && !stall_o && !flush_i; otherwise stage[1] SHALL become invalid (bubble).
REQ-024 Captured rem SHALL be 1 for a load, else issue_lat_i (with macro) or 0 (without macro).
REQ-025 issue_lat_i values above DEPTH-1 SHALL be clamped to DEPTH-1, so that every result is ready before leaving stage DEPTH.
REQ-026 When flush_i and stall conditions coincide, flush_i SHALL win: stall_o = 0 and a bubble enters stage 1.
REQ-027 stall_cnt_o SHALL increment by 1 on each edge where stall_o = 1, and SHALL hold at 16'hFFFF.
REQ-028 Writes to rd = 0 SHALL be tracked but SHALL never match.

Reset
REQ-029 While rst_i = 0, all entries SHALL be invalid and rem = 0, stall_cnt_o = 0, and consequently fwd_sel_o = 0 and stall_o = 0.
REQ-030 Reset asserted mid-stall SHALL clear state immediately, without waiting for a clock edge.

Configuration
REQ-031 With FWD_MULTICYCLE_EN defined, the issue_lat_i port and per-entry latency SHALL exist.
REQ-032 Without FWD_MULTICYCLE_EN, issue_lat_i SHALL be absent, rem SHALL be 1 bit wide, and only load-use hazards SHALL stall.

Structure
REQ-033 Package fwd_pkg SHALL hold the stage-entry struct typedef, the REG_ZERO constant and the select-width function.
REQ-034 Sub-module fwd_src_match SHALL perform one port's match and priority encode, instantiated NUM_SRC times.

Verification
REQ-035 Stage 1 writes x5, non-load; EX reads rs1 = x5 -> fwd_sel port0 = 1, stall_o = 0.
REQ-036 Stage 1 and stage 2 both write x7; rs2 = x7 -> port1 select = 1 (youngest wins).
REQ-037 Load to x3 in stage 1; EX reads x3 -> stall_o = 1 for one cycle, then select = 2, stall_o = 0, stall_cnt_o = 1.
REQ-038 rs1 = x0 with a stage writing x0 -> select = 0, no stall; also src_use_i = 0 with a matching rd -> no stall.
REQ-039 Load-use condition with flush_i = 1 -> stall_o = 0 and stage 1 becomes a bubble; rst_i pulsed low mid-stall -> all outputs 0 asynchronously.
REQ-040 With FWD_MULTICYCLE_EN, DEPTH = 4, op to x9 with issue_lat_i = 3 followed by a consumer of x9 -> stall_o = 1 for 3 cycles, then select = 4.

Source files
------------

// File: rtl/fwd_pkg.sv
// rtl/fwd_pkg.sv - stage-entry type, register-zero constant and select-width helper for the forward scoreboard
package fwd_pkg;

   // Register x0 is hardwired to zero and is never a forwarding source.
   localparam logic [4:0] REG_ZERO = 5'd0;

   // Remaining-latency width: 3 bits covers the largest clamp (DEPTH-1 = 7);
   // without multicycle ops only a load's single extra cycle is tracked.
`ifdef FWD_MULTICYCLE_EN
   localparam int REM_W = 3;
`else
   localparam int REM_W = 1;
`endif

   typedef struct packed {
      logic             valid;
      logic [4:0]       rd;
      logic             regwrite;
      logic [REM_W-1:0] rem;
   } stage_entry_t;

   // Width of one forward select: encodes 0 (register file) .. depth.
   function automatic int sel_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fwd_src_match.sv
// rtl/fwd_src_match.sv - one source port's match against all stages with youngest-first priority
module fwd_src_match
   import fwd_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned SEL_W = 2
) (
   input  stage_entry_t [DEPTH-1:0] stages,
   input  logic [4:0]               rs,
   input  logic                     use_src,
   output logic [SEL_W-1:0]         sel,
   output logic                     hazard
);

   // Scan oldest to youngest so the last hit, the smallest stage index, wins.
   always_comb begin
      sel    = '0;
      hazard = 1'b0;
      for (int k = DEPTH; k >= 1; k--) begin
         if (stages[k-1].valid && stages[k-1].regwrite && use_src &&
             stages[k-1].rd != REG_ZERO && stages[k-1].rd == rs) begin
            sel    = SEL_W'(k);
            hazard = (stages[k-1].rem != '0);
         end
      end
   end

endmodule

// File: rtl/forward_scoreboard.sv
// rtl/forward_scoreboard.sv - in-flight producer tracker giving forward selects and load-use stalls (option: FWD_MULTICYCLE_EN)
module forward_scoreboard
   import fwd_pkg::*;
#(
   parameter int unsigned NUM_SRC = 2,
   parameter int unsigned DEPTH   = 2,
   parameter int unsigned LAT_W   = 2
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic                               issue_valid_i,
   input  logic [4:0]                         issue_rd_i,
   input  logic                               issue_regwrite_i,
   input  logic                               issue_is_load_i,
`ifdef FWD_MULTICYCLE_EN
   input  logic [LAT_W-1:0]                   issue_lat_i,
`endif
   input  logic [NUM_SRC*5-1:0]               src_rs_i,
   input  logic [NUM_SRC-1:0]                 src_use_i,
   input  logic                               flush_i,
   output logic [NUM_SRC*sel_width(DEPTH)-1:0] fwd_sel_o,
   output logic                               stall_o,
   output logic [15:0]                        stall_cnt_o
);

   localparam int unsigned SEL_W = sel_width(DEPTH);

   if (DEPTH < 2 || DEPTH > 8 || LAT_W < 1) begin : g_bad_param
      $error("forward_scoreboard: DEPTH must be 2..8 and LAT_W at least 1");
   end

   // stage_q[k-1] holds stage k; index 0 is the youngest producer.
   stage_entry_t [DEPTH-1:0] stage_q;
   stage_entry_t [DEPTH-1:0] stage_d;
   logic [NUM_SRC-1:0]       hazard;
   logic [REM_W-1:0]         rem_in;
   logic                     capture;
   logic [15:0]              stall_cnt_q;

   for (genvar n = 0; n < NUM_SRC; n++) begin : g_src
      fwd_src_match #(
         .DEPTH (DEPTH),
         .SEL_W (SEL_W)
      ) u_match (
         .stages  (stage_q),
         .rs      (src_rs_i[5*n +: 5]),
         .use_src (src_use_i[n]),
         .sel     (fwd_sel_o[SEL_W*n +: SEL_W]),
         .hazard  (hazard[n])
      );
   end

   // Flush overrides any hazard; a stalled or flushed slot becomes a bubble.
   assign stall_o     = issue_valid_i && !flush_i && (|hazard);
   assign capture     = issue_valid_i && !flush_i && !stall_o;
   assign stall_cnt_o = stall_cnt_q;

   // Cycles until the new result is forwardable; long ops are clamped so they
   // are always ready by the time they reach the oldest tracked stage.
   always_comb begin
      rem_in = '0;
      if (issue_is_load_i) begin
         rem_in = REM_W'(1);
      end
`ifdef FWD_MULTICYCLE_EN
      else if (32'(issue_lat_i) > DEPTH - 1) begin
         rem_in = REM_W'(DEPTH - 1);
      end else begin
         rem_in = REM_W'(issue_lat_i);
      end
`endif
   end

   // Next pipeline contents: new entry or bubble in stage 1, older entries age by one.
   always_comb begin
      stage_d = '0;
      if (capture) begin
         stage_d[0].valid    = 1'b1;
         stage_d[0].rd       = issue_rd_i;
         stage_d[0].regwrite = issue_regwrite_i;
         stage_d[0].rem      = rem_in;
      end
      for (int k = 1; k < DEPTH; k++) begin
         stage_d[k] = stage_q[k-1];
         if (stage_q[k-1].rem != '0) begin
            stage_d[k].rem = stage_q[k-1].rem - REM_W'(1);
         end
      end
   end

   // Stage registers and saturating stall counter; reset clears everything at once.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         stage_q     <= '0;
         stall_cnt_q <= '0;
      end else begin
         stage_q <= stage_d;
         if (stall_o && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_forward_scoreboard.sv
// tb/tb_forward_scoreboard.sv - self-checking bench for forward_scoreboard (FWD_MULTICYCLE_EN aware)
module tb_forward_scoreboard;
   import fwd_pkg::*;

   localparam int NUM_SRC = 2;
   localparam int DEPTH   = 4;
   localparam int LAT_W   = 2;
   localparam int SEL_W   = $clog2(DEPTH + 1);

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic                     issue_valid;
   logic [4:0]               issue_rd;
   logic                     issue_regwrite;
   logic                     issue_is_load;
   logic [LAT_W-1:0]         issue_lat;
   logic [NUM_SRC*5-1:0]     src_rs;
   logic [NUM_SRC-1:0]       src_use;
   logic                     flush;
   logic [NUM_SRC*SEL_W-1:0] fwd_sel;
   logic                     stall;
   logic [15:0]              stall_cnt;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   forward_scoreboard #(
      .NUM_SRC (NUM_SRC),
      .DEPTH   (DEPTH),
      .LAT_W   (LAT_W)
   ) dut (
      .clk_i            (clk),
      .rst_i            (rst_n),
      .issue_valid_i    (issue_valid),
      .issue_rd_i       (issue_rd),
      .issue_regwrite_i (issue_regwrite),
      .issue_is_load_i  (issue_is_load),
`ifdef FWD_MULTICYCLE_EN
      .issue_lat_i      (issue_lat),
`endif
      .src_rs_i         (src_rs),
      .src_use_i        (src_use),
      .flush_i          (flush),
      .fwd_sel_o        (fwd_sel),
      .stall_o          (stall),
      .stall_cnt_o      (stall_cnt)
   );

   task automatic chk(input string name, input int act, input int exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic drive(input bit v, input int rd, input bit rw, input bit ld, input int lat,
                        input int rs0, input int rs1, input logic [1:0] u, input bit fl);
      issue_valid    = v;
      issue_rd       = 5'(rd);
      issue_regwrite = rw;
      issue_is_load  = ld;
      issue_lat      = LAT_W'(lat);
      src_rs         = {5'(rs1), 5'(rs0)};
      src_use        = u;
      flush          = fl;
   endtask

   function automatic int sel0();
      return int'(fwd_sel[SEL_W-1:0]);
   endfunction
   function automatic int sel1();
      return int'(fwd_sel[2*SEL_W-1:SEL_W]);
   endfunction

   // Directed vector table: one row per cycle, expectations worked out by hand.
   typedef struct {
      bit         valid;
      int         rd;
      bit         rw;
      bit         load;
      int         rs0;
      int         rs1;
      logic [1:0] uses;
      bit         flush;
      int         sel0;
      int         sel1;
      int         stall;
      int         cnt;
   } vec_t;

   function automatic vec_t mk(bit v, int rd, bit rw, bit ld, int rs0, int rs1, logic [1:0] u,
                               bit fl, int s0, int s1, int st, int c);
      vec_t r;
      r.valid = v; r.rd = rd; r.rw = rw; r.load = ld; r.rs0 = rs0; r.rs1 = rs1;
      r.uses = u; r.flush = fl; r.sel0 = s0; r.sel1 = s1; r.stall = st; r.cnt = c;
      return r;
   endfunction

   // Reference model: each in-flight producer carries the absolute cycle at
   // which its result becomes available; hist[k] is the k-th most recent slot.
   typedef struct {
      bit valid;
      int rd;
      bit rw;
      int ready;
   } prod_t;

   prod_t hist[1:DEPTH];
   int    cyc;
   int    mcnt;

   task automatic model_reset();
      for (int k = 1; k <= DEPTH; k++) hist[k] = '{1'b0, 0, 1'b0, 0};
      cyc  = 0;
      mcnt = 0;
   endtask

   function automatic int model_sel(input int rs, input bit u);
      int s = 0;
      for (int k = DEPTH; k >= 1; k--)
         if (u && hist[k].valid && hist[k].rw && hist[k].rd != 0 && hist[k].rd == rs) s = k;
      return s;
   endfunction

   function automatic bit model_stall(input bit v, input bit fl, input int s0, input int s1);
      bit late = 1'b0;
      if (s0 != 0 && hist[s0].ready > cyc) late = 1'b1;
      if (s1 != 0 && hist[s1].ready > cyc) late = 1'b1;
      return v && !fl && late;
   endfunction

   task automatic model_step(input bit v, input int rd, input bit rw, input bit ld, input int lat,
                             input bit fl, input bit st);
      int l;
`ifdef FWD_MULTICYCLE_EN
      l = ld ? 1 : ((lat > DEPTH - 1) ? DEPTH - 1 : lat);
`else
      l = ld ? 1 : 0;
`endif
      if (st && mcnt < 65535) mcnt++;
      for (int k = DEPTH; k >= 2; k--) hist[k] = hist[k-1];
      if (v && !fl && !st) hist[1] = '{1'b1, rd, rw, cyc + 1 + l};
      else                 hist[1] = '{1'b0, 0, 1'b0, 0};
      cyc++;
   endtask

   vec_t vt[11];

   initial begin
      vt[0]  = mk(1, 5, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
      vt[1]  = mk(1, 7, 1, 0, 5, 0, 2'b01, 0, 1, 0, 0, 0);
      vt[2]  = mk(1, 7, 1, 0, 5, 7, 2'b11, 0, 2, 1, 0, 0);
      vt[3]  = mk(1, 3, 1, 1, 7, 7, 2'b11, 0, 1, 1, 0, 0);
      vt[4]  = mk(1, 8, 1, 0, 3, 0, 2'b01, 0, 1, 0, 1, 0);
      vt[5]  = mk(1, 8, 1, 0, 3, 0, 2'b01, 0, 2, 0, 0, 1);
      vt[6]  = mk(1, 0, 1, 0, 0, 0, 2'b11, 0, 0, 0, 0, 1);
      vt[7]  = mk(1, 1, 1, 1, 0, 8, 2'b01, 0, 0, 0, 0, 1);
      vt[8]  = mk(1, 2, 1, 0, 1, 0, 2'b01, 1, 1, 0, 0, 1);
      vt[9]  = mk(0, 0, 0, 0, 1, 8, 2'b11, 0, 2, 4, 0, 1);
      vt[10] = mk(0, 0, 0, 0, 2, 1, 2'b11, 0, 0, 3, 0, 1);

      // Reset state, with inputs that would otherwise hit.
      rst_n = 1'b0;
      drive(1, 5, 1, 1, 0, 5, 5, 2'b11, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset sel0", sel0(), 0);
      chk("reset sel1", sel1(), 0);
      chk("reset stall", int'(stall), 0);
      chk("reset cnt", int'(stall_cnt), 0);
      drive(0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 11; i++) begin
         drive(vt[i].valid, vt[i].rd, vt[i].rw, vt[i].load, 0, vt[i].rs0, vt[i].rs1,
               vt[i].uses, vt[i].flush);
         @(negedge clk);
         chk($sformatf("row%0d sel0", i), sel0(), vt[i].sel0);
         chk($sformatf("row%0d sel1", i), sel1(), vt[i].sel1);
         chk($sformatf("row%0d stall", i), int'(stall), vt[i].stall);
         chk($sformatf("row%0d cnt", i), int'(stall_cnt), vt[i].cnt);
         @(posedge clk); #1;
      end

      // Reset asserted during a load-use stall clears outputs without a clock edge.
      drive(1, 3, 1, 1, 0, 0, 0, 2'b00, 0);
      @(posedge clk); #1;
      drive(1, 4, 1, 0, 0, 3, 0, 2'b01, 0);
      @(negedge clk);
      chk("pre-reset stall", int'(stall), 1);
      chk("pre-reset cnt", int'(stall_cnt), 1);
      #1 rst_n = 1'b0;
      #1;
      chk("async reset stall", int'(stall), 0);
      chk("async reset sel0", sel0(), 0);
      chk("async reset cnt", int'(stall_cnt), 0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
      @(posedge clk); #1;

      // Producer to x9 followed by a consumer of x9.
`ifdef FWD_MULTICYCLE_EN
      drive(1, 9, 1, 0, 3, 0, 0, 2'b00, 0);
      @(posedge clk); #1;
      drive(1, 10, 1, 0, 0, 9, 0, 2'b01, 0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("lat3 stall c%0d", c), int'(stall), 1);
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("lat3 released", int'(stall), 0);
      chk("lat3 sel0", sel0(), 4);
      chk("lat3 cnt", int'(stall_cnt), 3);
`else
      drive(1, 9, 1, 0, 3, 0, 0, 2'b00, 0);
      @(posedge clk); #1;
      drive(1, 10, 1, 0, 0, 9, 0, 2'b01, 0);
      @(negedge clk);
      chk("alu no stall", int'(stall), 0);
      chk("alu sel0", sel0(), 1);
`endif
      @(posedge clk); #1;

      // Randomized traffic against the reference model.
      drive(0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
      rst_n = 1'b0;
      #1 rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 400; i++) begin
         bit v, rw, ld, fl, st;
         int rd, lat, rs0, rs1, s0, s1;
         logic [1:0] u;
         v   = ($urandom_range(0, 9) < 8);
         rd  = $urandom_range(0, 3);
         rw  = ($urandom_range(0, 9) < 9);
         ld  = ($urandom_range(0, 9) < 4);
         lat = $urandom_range(0, 3);
         rs0 = $urandom_range(0, 3);
         rs1 = $urandom_range(0, 3);
         u   = 2'($urandom_range(0, 3));
         fl  = ($urandom_range(0, 9) == 0);
         drive(v, rd, rw, ld, lat, rs0, rs1, u, fl);
         s0 = model_sel(rs0, u[0]);
         s1 = model_sel(rs1, u[1]);
         st = model_stall(v, fl, s0, s1);
         @(negedge clk);
         chk($sformatf("rand%0d sel0", i), sel0(), s0);
         chk($sformatf("rand%0d sel1", i), sel1(), s1);
         chk($sformatf("rand%0d stall", i), int'(stall), int'(st));
         chk($sformatf("rand%0d cnt", i), int'(stall_cnt), mcnt);
         @(posedge clk);
         model_step(v, rd, rw, ld, lat, fl, st);
         #1;
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
